// File: rtl/pipe_ctrl_if.sv
// Pipeline-control signal bundle: hazard/status inputs from the stages and
// the sequencing/forwarding decisions returned by the controller.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [2:0]       dec_rs1, dec_rs2;
    logic             dec_use1, dec_use2, dec_halt;
    logic [2:0]       ex_rs1, ex_rs2;
    logic             ex_use1, ex_use2;
    logic             ex_mem_read, ex_write_en;
    logic [2:0]       ex_write_reg;
    logic             ex_redirect;
    logic             mem_write_en;
    logic [2:0]       mem_write_reg;
    logic             wb_write_en;
    logic [2:0]       wb_write_reg;
    logic             wb_halt;

    logic             pc_en, fd_en, fd_flush, de_flush;
    logic [1:0]       fwd_a, fwd_b;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output dec_rs1, dec_rs2, dec_use1, dec_use2, dec_halt,
               ex_rs1, ex_rs2, ex_use1, ex_use2, ex_mem_read, ex_write_en,
               ex_write_reg, ex_redirect, mem_write_en, mem_write_reg,
               wb_write_en, wb_write_reg, wb_halt,
        input  pc_en, fd_en, fd_flush, de_flush, fwd_a, fwd_b, halted,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  dec_rs1, dec_rs2, dec_use1, dec_use2, dec_halt,
               ex_rs1, ex_rs2, ex_use1, ex_use2, ex_mem_read, ex_write_en,
               ex_write_reg, ex_redirect, mem_write_en, mem_write_reg,
               wb_write_en, wb_write_reg, wb_halt,
        output pc_en, fd_en, fd_flush, de_flush, fwd_a, fwd_b, halted,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencing controller: load-use stalls, redirect squash,
// halt drain, operand forwarding and saturating stall/flush event counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,   // active-low, asynchronous assert
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             lu;
    logic             pc_en_c, fd_en_c, fd_flush_c, de_flush_c;

    function automatic logic [1:0] fwd_sel(
        input logic       use_rs,
        input logic [2:0] rs,
        input logic       mem_we,
        input logic [2:0] mem_rd,
        input logic       wb_we,
        input logic [2:0] wb_rd
    );
        if (use_rs && mem_we && (mem_rd == rs)) return 2'b01;
        if (use_rs && wb_we  && (wb_rd  == rs)) return 2'b10;
        return 2'b00;
    endfunction

    assign lu = bus.ex_mem_read & bus.ex_write_en &
                ((bus.dec_use1 & (bus.dec_rs1 == bus.ex_write_reg)) |
                 (bus.dec_use2 & (bus.dec_rs2 == bus.ex_write_reg)));

    // Forwarding select is purely combinational and independent of state.
    always_comb begin
        bus.fwd_a = fwd_sel(bus.ex_use1, bus.ex_rs1, bus.mem_write_en,
                            bus.mem_write_reg, bus.wb_write_en, bus.wb_write_reg);
        bus.fwd_b = fwd_sel(bus.ex_use2, bus.ex_rs2, bus.mem_write_en,
                            bus.mem_write_reg, bus.wb_write_en, bus.wb_write_reg);
    end

    // Next state, counter updates and pipeline enables; reset forces NOP fill.
    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        pc_en_c    = 1'b0;
        fd_en_c    = 1'b0;
        fd_flush_c = 1'b0;
        de_flush_c = 1'b0;
        if (!rst) begin
            fd_flush_c = 1'b1;
            de_flush_c = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.ex_redirect) begin
                        pc_en_c    = 1'b1;
                        fd_en_c    = 1'b1;
                        fd_flush_c = 1'b1;
                        de_flush_c = 1'b1;
                        if (flush_q != '1) flush_d = flush_q + CNT_ONE;
                    end else if (lu) begin
                        de_flush_c = 1'b1;
                        if (stall_q != '1) stall_d = stall_q + CNT_ONE;
                    end else if (bus.dec_halt) begin
                        fd_en_c    = 1'b1;
                        fd_flush_c = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        pc_en_c = 1'b1;
                        fd_en_c = 1'b1;
                    end
                end
                DRAIN: begin
                    fd_en_c    = 1'b1;
                    fd_flush_c = 1'b1;
                    de_flush_c = 1'b1;
                    if (bus.wb_halt) state_d = HALTED;
                end
                HALTED: state_d = HALTED;
                default: state_d = RUN;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.pc_en     = pc_en_c;
    assign bus.fd_en     = fd_en_c;
    assign bus.fd_flush  = fd_flush_c;
    assign bus.de_flush  = de_flush_c;
    assign bus.halted    = (state_q == HALTED);
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver issues stimulus and pushes the
// reference-model expectation; monitor pops and compares on the falling edge.
module tb_pipe_ctrl;
    localparam int unsigned CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;

    typedef struct {
        logic       rst;
        logic [2:0] dec_rs1, dec_rs2;
        logic       dec_use1, dec_use2, dec_halt;
        logic [2:0] ex_rs1, ex_rs2;
        logic       ex_use1, ex_use2, ex_mem_read, ex_write_en;
        logic [2:0] ex_write_reg;
        logic       ex_redirect, mem_write_en;
        logic [2:0] mem_write_reg;
        logic       wb_write_en;
        logic [2:0] wb_write_reg;
        logic       wb_halt;
    } stim_t;

    typedef struct {
        int pc_en, fd_en, fd_flush, de_flush, fwd_a, fwd_b, halted, stall, flush;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();
    pipe_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0 = running, 1 = draining, 2 = halted.
    int m_mode  = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int fwd_ref(input logic u, input logic [2:0] rs, input stim_t s);
        if (u && s.mem_write_en && s.mem_write_reg == rs) return 1;
        if (u && s.wb_write_en && s.wb_write_reg == rs) return 2;
        return 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst           = ($urandom_range(0, 63) != 0);
        s.dec_rs1       = 3'($urandom_range(0, 3));
        s.dec_rs2       = 3'($urandom_range(0, 3));
        s.dec_use1      = 1'($urandom);
        s.dec_use2      = 1'($urandom);
        s.dec_halt      = ($urandom_range(0, 15) == 0);
        s.ex_rs1        = 3'($urandom_range(0, 3));
        s.ex_rs2        = 3'($urandom_range(0, 3));
        s.ex_use1       = 1'($urandom);
        s.ex_use2       = 1'($urandom);
        s.ex_mem_read   = 1'($urandom);
        s.ex_write_en   = 1'($urandom);
        s.ex_write_reg  = 3'($urandom_range(0, 3));
        s.ex_redirect   = ($urandom_range(0, 7) == 0);
        s.mem_write_en  = 1'($urandom);
        s.mem_write_reg = 3'($urandom_range(0, 3));
        s.wb_write_en   = 1'($urandom);
        s.wb_write_reg  = 3'($urandom_range(0, 3));
        s.wb_halt       = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    // Apply one cycle of stimulus just after the rising edge, record expectation.
    task automatic drive(input stim_t s);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst               = s.rst;
        bus.dec_rs1       = s.dec_rs1;
        bus.dec_rs2       = s.dec_rs2;
        bus.dec_use1      = s.dec_use1;
        bus.dec_use2      = s.dec_use2;
        bus.dec_halt      = s.dec_halt;
        bus.ex_rs1        = s.ex_rs1;
        bus.ex_rs2        = s.ex_rs2;
        bus.ex_use1       = s.ex_use1;
        bus.ex_use2       = s.ex_use2;
        bus.ex_mem_read   = s.ex_mem_read;
        bus.ex_write_en   = s.ex_write_en;
        bus.ex_write_reg  = s.ex_write_reg;
        bus.ex_redirect   = s.ex_redirect;
        bus.mem_write_en  = s.mem_write_en;
        bus.mem_write_reg = s.mem_write_reg;
        bus.wb_write_en   = s.wb_write_en;
        bus.wb_write_reg  = s.wb_write_reg;
        bus.wb_halt       = s.wb_halt;

        lu = s.ex_mem_read && s.ex_write_en &&
             ((s.dec_use1 && s.dec_rs1 == s.ex_write_reg) ||
              (s.dec_use2 && s.dec_rs2 == s.ex_write_reg));
        e.fwd_a = fwd_ref(s.ex_use1, s.ex_rs1, s);
        e.fwd_b = fwd_ref(s.ex_use2, s.ex_rs2, s);

        if (!s.rst) begin
            m_mode = 0; m_stall = 0; m_flush = 0;
            e.pc_en = 0; e.fd_en = 0; e.fd_flush = 1; e.de_flush = 1;
            e.halted = 0; e.stall = 0; e.flush = 0;
        end else begin
            e.halted = (m_mode == 2);
            e.stall  = m_stall;
            e.flush  = m_flush;
            if (m_mode == 0) begin
                if (s.ex_redirect) begin
                    e.pc_en = 1; e.fd_en = 1; e.fd_flush = 1; e.de_flush = 1;
                    if (m_flush < MAXC) m_flush++;
                end else if (lu) begin
                    e.pc_en = 0; e.fd_en = 0; e.fd_flush = 0; e.de_flush = 1;
                    if (m_stall < MAXC) m_stall++;
                end else if (s.dec_halt) begin
                    e.pc_en = 0; e.fd_en = 1; e.fd_flush = 1; e.de_flush = 0;
                    m_mode = 1;
                end else begin
                    e.pc_en = 1; e.fd_en = 1; e.fd_flush = 0; e.de_flush = 0;
                end
            end else if (m_mode == 1) begin
                e.pc_en = 0; e.fd_en = 1; e.fd_flush = 1; e.de_flush = 1;
                if (s.wb_halt) m_mode = 2;
            end else begin
                e.pc_en = 0; e.fd_en = 0; e.fd_flush = 0; e.de_flush = 0;
            end
        end
        q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("pc_en",     int'(bus.pc_en),     e.pc_en);
                check("fd_en",     int'(bus.fd_en),     e.fd_en);
                check("fd_flush",  int'(bus.fd_flush),  e.fd_flush);
                check("de_flush",  int'(bus.de_flush),  e.de_flush);
                check("fwd_a",     int'(bus.fwd_a),     e.fwd_a);
                check("fwd_b",     int'(bus.fwd_b),     e.fwd_b);
                check("halted",    int'(bus.halted),    e.halted);
                check("stall_cnt", int'(bus.stall_cnt), e.stall);
                check("flush_cnt", int'(bus.flush_cnt), e.flush);
            end
        end
    end

    initial begin
        stim_t s;
        stim_t ld;
        s = idle();
        {bus.dec_rs1, bus.dec_rs2, bus.dec_use1, bus.dec_use2, bus.dec_halt} = '0;
        {bus.ex_rs1, bus.ex_rs2, bus.ex_use1, bus.ex_use2} = '0;
        {bus.ex_mem_read, bus.ex_write_en, bus.ex_write_reg, bus.ex_redirect} = '0;
        {bus.mem_write_en, bus.mem_write_reg, bus.wb_write_en, bus.wb_write_reg} = '0;
        bus.wb_halt = 1'b0;

        // Reset state
        s.rst = 1'b0;
        drive(s);
        drive(s);
        drive(idle());

        // Load-use stall, then load removed
        ld = idle();
        ld.ex_mem_read = 1; ld.ex_write_en = 1; ld.ex_write_reg = 3;
        ld.dec_use1 = 1; ld.dec_rs1 = 3;
        drive(ld);
        drive(idle());
        // Same registers, use bits clear: no stall
        s = ld; s.dec_use1 = 0; s.dec_use2 = 0; s.dec_rs2 = 3;
        drive(s);
        // Redirect alone, then redirect with load-use
        s = idle(); s.ex_redirect = 1;
        drive(s);
        s = ld; s.ex_redirect = 1;
        drive(s);
        drive(idle());

        // Forwarding priority
        s = idle();
        s.ex_use1 = 1; s.ex_rs1 = 5;
        s.mem_write_en = 1; s.mem_write_reg = 5;
        s.wb_write_en = 1; s.wb_write_reg = 5;
        drive(s);
        s.mem_write_en = 0;
        drive(s);
        s.wb_write_en = 0;
        drive(s);

        // Halt drain
        s = idle(); s.dec_halt = 1;
        drive(s);
        for (int i = 0; i < 3; i++) drive(idle());
        s = idle(); s.wb_halt = 1;
        drive(s);
        for (int i = 0; i < 10; i++) drive(idle());
        s = idle(); s.rst = 0;
        drive(s);
        drive(idle());

        // Saturation: back-to-back stalls
        for (int i = 0; i < 22; i++) drive(ld);
        @(negedge clk);
        check("stall_sat", int'(bus.stall_cnt), MAXC);
        s = idle(); s.rst = 0;
        drive(s);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) drive(rnd());
        drive(idle());

        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before %0t", $time);
        $fatal(1);
    end
endmodule
